// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Staged reset sequencer for the capture card. It sits between the board-level
// reset and the per-domain reset inputs. The domains are clocking, memory
// interface, link and capture datapath. They are released one at a time in
// ascending order. Each released stage must report ready within P_TIMEOUT
// cycles before the next stage is released. A stage that misses its window
// restarts the whole sequence. After P_RETRY such restarts the block latches a
// fault and waits for a soft or board reset.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_soft_rst   synchronous active-high restart request
//   i_ready      per-stage ready/lock, asynchronous to i_clk
//   o_rst        per-stage reset, active-high
//   o_done       all stages released and ready
//   o_fault      retries exhausted, sequence halted
//   o_stage      current stage index; P_STAGES in DONE (3 bits, so
//                P_STAGES=8 reads back as 0 in DONE)
//   o_retry_cnt  timeouts taken in the current sequence
//
// Every output is driven directly by a flop, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int P_STAGES     = 3,
  parameter int P_HOLD_CYCLE = 16,
  parameter int P_GAP_CYCLE  = 8,
  parameter int P_TIMEOUT    = 1000,
  parameter int P_RETRY      = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_soft_rst,
  input  logic [P_STAGES-1:0] i_ready,
  output logic [P_STAGES-1:0] o_rst,
  output logic                o_done,
  output logic                o_fault,
  output logic [2:0]          o_stage,
  output logic [3:0]          o_retry_cnt
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [15:0] HOLD_LAST  = 16'(P_HOLD_CYCLE - 1);
  localparam logic [15:0] GAP_LAST   = 16'((P_GAP_CYCLE > 0) ? (P_GAP_CYCLE - 1) : 0);
  localparam logic [15:0] TMO_LAST   = 16'(P_TIMEOUT - 1);
  localparam logic [2:0]  LAST_STAGE = 3'(P_STAGES - 1);
  localparam logic [2:0]  STAGE_DONE = 3'(P_STAGES);
  localparam logic [3:0]  RETRY_MAX  = 4'(P_RETRY);
  localparam bit          NO_GAP     = (P_GAP_CYCLE == 0);

  state_t              state;
  state_t              state_nx;
  logic [2:0]          stage;
  logic [2:0]          stage_nx;
  logic [15:0]         cnt;
  logic [15:0]         cnt_nx;
  logic [3:0]          retry;
  logic [3:0]          retry_nx;
  logic [P_STAGES-1:0] rdy_meta;
  logic [P_STAGES-1:0] rdy_s;
  logic [P_STAGES-1:0] rst_nx;
  logic                rdy_cur;
  logic                cnt_clr;
  logic                advance;
  logic                stage_fail;

  // Ready bits come from other clock domains (PLL lock, PHY ready, ...).
  // They are double-flopped before any decision looks at them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_meta <= '0;
      rdy_s    <= '0;
    end else begin
      rdy_meta <= i_ready;
      rdy_s    <= rdy_meta;
    end
  end

  // This is the synchronised ready of the stage currently being brought up.
  // A loop compare is used here instead of a variable index, so the mux stays
  // in range for every P_STAGES value.
  always_comb begin
    rdy_cur = 1'b0;
    for (int i = 0; i < P_STAGES; i++) begin
      if (i == int'(stage)) rdy_cur = rdy_s[i];
    end
  end

  // Next-state logic. Each state only raises the events "advance" (the stage
  // is settled, move on) or "stage_fail" (timeout, or ready lost during the
  // gap). The shared handling after the case statement then resolves those
  // events. Soft reset is applied last so that it overrides everything else
  // on the same edge.
  always_comb begin
    state_nx   = state;
    stage_nx   = stage;
    retry_nx   = retry;
    cnt_clr    = 1'b0;
    advance    = 1'b0;
    stage_fail = 1'b0;

    case (state)
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = S_WAIT;
          stage_nx = '0;
          cnt_clr  = 1'b1;
        end
      end
      S_WAIT: begin
        // If ready and timeout arrive on the same edge, ready is checked first.
        if (rdy_cur) begin
          if (NO_GAP) begin
            advance = 1'b1;
          end else begin
            state_nx = S_GAP;
            cnt_clr  = 1'b1;
          end
        end else if (cnt == TMO_LAST) begin
          stage_fail = 1'b1;
        end
      end
      S_GAP: begin
        // A stage that loses ready while settling is treated as a timeout.
        // This takes priority over gap expiry on the same edge.
        if (!rdy_cur) begin
          stage_fail = 1'b1;
        end else if (cnt == GAP_LAST) begin
          advance = 1'b1;
        end
      end
      S_DONE: begin
        // A runtime loss of any domain restarts the whole sequence, and this
        // restart does not use up a retry.
        if (rdy_s != '1) begin
          state_nx = S_HOLD;
          stage_nx = '0;
          retry_nx = '0;
          cnt_clr  = 1'b1;
        end
      end
      S_FAULT: begin
      end
      default: begin
        state_nx = S_HOLD;
        stage_nx = '0;
        cnt_clr  = 1'b1;
      end
    endcase

    if (advance) begin
      cnt_clr = 1'b1;
      if (stage == LAST_STAGE) begin
        state_nx = S_DONE;
        stage_nx = STAGE_DONE;
      end else begin
        state_nx = S_WAIT;
        stage_nx = stage + 3'd1;
      end
    end

    if (stage_fail) begin
      cnt_clr = 1'b1;
      if (retry < RETRY_MAX) begin
        retry_nx = retry + 4'd1;
        state_nx = S_HOLD;
        stage_nx = '0;
      end else begin
        state_nx = S_FAULT;
      end
    end

    if (i_soft_rst) begin
      state_nx = S_HOLD;
      stage_nx = '0;
      retry_nx = '0;
      cnt_clr  = 1'b1;
    end
  end

  // The counter only runs in states that time something. It is held at zero
  // in DONE and FAULT, so it cannot wrap while the block is parked there.
  always_comb begin
    if (cnt_clr || (state == S_DONE) || (state == S_FAULT)) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt + 16'd1;
    end
  end

  // The reset pattern is decoded from the next state, so the registered
  // o_rst changes on the same edge as the state.
  // Stages 0..k are released in WAIT(k) and GAP(k); the later stages stay held.
  always_comb begin
    rst_nx = '1;
    case (state_nx)
      S_WAIT, S_GAP: begin
        for (int i = 0; i < P_STAGES; i++) begin
          rst_nx[i] = (i > int'(stage_nx));
        end
      end
      S_DONE:  rst_nx = '0;
      default: rst_nx = '1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_HOLD;
      stage   <= '0;
      cnt     <= '0;
      retry   <= '0;
      o_rst   <= '1;
      o_done  <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      state   <= state_nx;
      stage   <= stage_nx;
      cnt     <= cnt_nx;
      retry   <= retry_nx;
      o_rst   <= rst_nx;
      o_done  <= (state_nx == S_DONE);
      o_fault <= (state_nx == S_FAULT);
    end
  end

  assign o_stage     = stage;
  assign o_retry_cnt = retry;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Self-checking bench for rst_seq_ctrl. It uses two instances:
//   u_dut    default parameters (3 stages, hold 16, gap 8, timeout 1000,
//            retry 2)
//   u_dut_c  corner parameters (1 stage, no gap, no retry)
// Expected edge numbers come from a small timing model. The model works in
// plain arithmetic on the sequencing rules: hold length, synchroniser latency,
// gap length, timeout window and retry budget.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int NS    = 3;
  localparam int HOLD  = 16;
  localparam int GAP   = 8;
  localparam int TMO   = 1000;
  localparam int RETRY = 2;
  localparam int SYNC  = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_soft_rst;
  logic [NS-1:0] i_ready;
  logic [NS-1:0] o_rst;
  logic          o_done;
  logic          o_fault;
  logic [2:0]    o_stage;
  logic [3:0]    o_retry_cnt;

  logic          c_rst_n;
  logic          c_soft_rst;
  logic [0:0]    c_ready;
  logic [0:0]    c_rst;
  logic          c_done;
  logic          c_fault;
  logic [2:0]    c_stage;
  logic [3:0]    c_retry_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = 0;

  always #5 i_clk = ~i_clk;

  rst_seq_ctrl #(
    .P_STAGES(NS), .P_HOLD_CYCLE(HOLD), .P_GAP_CYCLE(GAP),
    .P_TIMEOUT(TMO), .P_RETRY(RETRY)
  ) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst),
    .i_ready(i_ready), .o_rst(o_rst), .o_done(o_done), .o_fault(o_fault),
    .o_stage(o_stage), .o_retry_cnt(o_retry_cnt)
  );

  rst_seq_ctrl #(
    .P_STAGES(1), .P_HOLD_CYCLE(HOLD), .P_GAP_CYCLE(0),
    .P_TIMEOUT(TMO), .P_RETRY(0)
  ) u_dut_c (
    .i_clk(i_clk), .i_rst_n(c_rst_n), .i_soft_rst(c_soft_rst),
    .i_ready(c_ready), .o_rst(c_rst), .o_done(c_done), .o_fault(c_fault),
    .o_stage(c_stage), .o_retry_cnt(c_retry_cnt)
  );

  // Timing model. Suppose a stage's ready is raised d edges after that stage
  // is released. The ready crosses the synchroniser and is acted on one edge
  // later, so WAIT exits d+SYNC+1 edges after the release. The timeout fires
  // after TMO edges. Returns -1 when the timeout comes first.
  function automatic int model_wait_exit(input int d);
    int seen;
    seen = d + SYNC + 1;
    return (seen <= TMO) ? seen : -1;
  endfunction

  // Suppose stage s never reports ready and the stages below it are ready
  // from the start. Each attempt then lasts HOLD + s*(GAP+1) + TMO edges.
  function automatic int model_period(input int s);
    return HOLD + s * (GAP + 1) + TMO;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
    edge_no++;
  endtask

  task automatic do_reset(input logic [NS-1:0] rdy);
    i_rst_n    = 1'b0;
    i_soft_rst = 1'b0;
    i_ready    = rdy;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic c_reset(input logic rdy);
    c_rst_n    = 1'b0;
    c_soft_rst = 1'b0;
    c_ready    = rdy;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    c_rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; c_rst_n = 1'b0;
    i_soft_rst = 1'b0; c_soft_rst = 1'b0;
    i_ready = '1; c_ready = 1'b1;
    repeat (2) tick();
    vectors++; if (o_rst !== '1) begin miscompares++; $display("[TB] FAIL reset_rst: got %b, expected %b", o_rst, 3'b111); end
    vectors++; if (o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", o_done); end
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fault: got %b, expected 0", o_fault); end
    vectors++; if (o_stage !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_stage: got %0d, expected 0", o_stage); end
    vectors++; if (o_retry_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_retry: got %0d, expected 0", o_retry_cnt); end
    vectors++; if (c_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_c_rst: got %b, expected 1", c_rst); end
    vectors++; if (c_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_c_done: got %b, expected 0", c_done); end
  endtask

  task automatic test_nominal();
    int fall [NS];
    int done_e;
    int retry_bad;
    int exp_e;
    do_reset('1);
    for (int k = 0; k < NS; k++) fall[k] = -1;
    done_e = -1;
    retry_bad = 0;
    for (int n = 0; n < 120 && done_e < 0; n++) begin
      tick();
      for (int k = 0; k < NS; k++) if (fall[k] < 0 && o_rst[k] === 1'b0) fall[k] = edge_no;
      if (o_done === 1'b1) done_e = edge_no;
      if (o_retry_cnt !== 4'd0) retry_bad++;
    end
    for (int k = 0; k < NS; k++) begin
      exp_e = HOLD + k * (GAP + 1);
      vectors++;
      if (fall[k] !== exp_e) begin miscompares++; $display("[TB] FAIL nominal_rel%0d: got edge %0d, expected %0d", k, fall[k], exp_e); end
    end
    exp_e = HOLD + NS * (GAP + 1);
    vectors++; if (done_e !== exp_e) begin miscompares++; $display("[TB] FAIL nominal_done: got edge %0d, expected %0d", done_e, exp_e); end
    vectors++; if (retry_bad !== 0) begin miscompares++; $display("[TB] FAIL nominal_retry: %0d edges with nonzero retry, expected 0", retry_bad); end
    vectors++; if (o_stage !== 3'(NS)) begin miscompares++; $display("[TB] FAIL nominal_stage: got %0d, expected %0d", o_stage, NS); end
    vectors++; if (o_rst !== '0) begin miscompares++; $display("[TB] FAIL nominal_rst_done: got %b, expected 000", o_rst); end
  endtask

  task automatic test_random_late(input int iter);
    int d [NS];
    int rel_obs [NS+1];
    int rel_exp [NS+1];
    int retry_bad;
    for (int k = 0; k < NS; k++) d[k] = int'($urandom_range(0, 400));
    // Put stage 1's ready on the very edge its timeout would fire.
    if (iter == 0) d[1] = TMO - SYNC - 1;
    do_reset('0);
    for (int k = 0; k <= NS; k++) rel_obs[k] = -1;
    retry_bad = 0;
    rel_exp[0] = HOLD;
    for (int k = 0; k < NS; k++) rel_exp[k+1] = rel_exp[k] + model_wait_exit(d[k]) + GAP;
    for (int n = 0; n < 5000 && rel_obs[NS] < 0; n++) begin
      tick();
      for (int k = 0; k < NS; k++) begin
        if (rel_obs[k] < 0 && o_rst[k] === 1'b0) rel_obs[k] = edge_no;
        if (rel_obs[k] >= 0 && edge_no == rel_obs[k] + d[k]) i_ready[k] = 1'b1;
      end
      if (o_done === 1'b1) rel_obs[NS] = edge_no;
      if (o_retry_cnt !== 4'd0) retry_bad++;
    end
    for (int k = 0; k <= NS; k++) begin
      vectors++;
      if (rel_obs[k] !== rel_exp[k]) begin
        miscompares++;
        $display("[TB] FAIL late%0d_ev%0d: got edge %0d, expected %0d (d=%0d/%0d/%0d)", iter, k, rel_obs[k], rel_exp[k], d[0], d[1], d[2]);
      end
    end
    vectors++; if (retry_bad !== 0) begin miscompares++; $display("[TB] FAIL late%0d_retry: %0d edges with nonzero retry, expected 0", iter, retry_bad); end
  endtask

  task automatic test_timeout_fault(input int s);
    logic [NS-1:0] rdy;
    int re_edge [$];
    int re_retry [$];
    int fault_e, per, stuck, got_e, got_r;
    logic all_prev;
    rdy = '0;
    for (int k = 0; k < s; k++) rdy[k] = 1'b1;
    do_reset(rdy);
    per = model_period(s);
    fault_e = -1;
    all_prev = 1'b1;
    for (int n = 0; n < (RETRY + 1) * per + 40 && fault_e < 0; n++) begin
      tick();
      if (o_fault === 1'b1) fault_e = edge_no;
      else if (!all_prev && o_rst === '1) begin
        re_edge.push_back(edge_no);
        re_retry.push_back(int'(o_retry_cnt));
      end
      all_prev = (o_rst === '1);
    end
    vectors++; if (re_edge.size() !== RETRY) begin miscompares++; $display("[TB] FAIL tmo%0d_count: got %0d restarts, expected %0d", s, re_edge.size(), RETRY); end
    for (int i = 0; i < RETRY; i++) begin
      got_e = (i < re_edge.size()) ? re_edge[i] : -1;
      got_r = (i < re_retry.size()) ? re_retry[i] : -1;
      vectors++; if (got_e !== (i + 1) * per) begin miscompares++; $display("[TB] FAIL tmo%0d_edge%0d: got %0d, expected %0d", s, i, got_e, (i + 1) * per); end
      vectors++; if (got_r !== i + 1) begin miscompares++; $display("[TB] FAIL tmo%0d_retry%0d: got %0d, expected %0d", s, i, got_r, i + 1); end
    end
    vectors++; if (fault_e !== (RETRY + 1) * per) begin miscompares++; $display("[TB] FAIL tmo%0d_fault: got edge %0d, expected %0d", s, fault_e, (RETRY + 1) * per); end
    vectors++; if (o_retry_cnt !== 4'(RETRY)) begin miscompares++; $display("[TB] FAIL tmo%0d_fault_retry: got %0d, expected %0d", s, o_retry_cnt, RETRY); end
    stuck = 0;
    repeat (40) begin
      tick();
      if (o_rst !== '1 || o_done !== 1'b0 || o_fault !== 1'b1) stuck++;
    end
    vectors++; if (stuck !== 0) begin miscompares++; $display("[TB] FAIL tmo%0d_hold: %0d edges left fault pattern, expected 0", s, stuck); end
  endtask

  task automatic test_soft_fault();
    int base, done_e;
    vectors++; if (o_fault !== 1'b1) begin miscompares++; $display("[TB] FAIL soft_pre: fault got %b, expected 1", o_fault); end
    i_ready = '1;
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    base = edge_no;
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("[TB] FAIL soft_fault_clr: got %b, expected 0", o_fault); end
    vectors++; if (o_rst !== '1) begin miscompares++; $display("[TB] FAIL soft_rst_all: got %b, expected 111", o_rst); end
    vectors++; if (o_retry_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL soft_retry: got %0d, expected 0", o_retry_cnt); end
    done_e = -1;
    for (int n = 0; n < 100 && done_e < 0; n++) begin
      tick();
      if (o_done === 1'b1) done_e = edge_no;
    end
    vectors++; if (done_e !== base + HOLD + NS * (GAP + 1)) begin miscompares++; $display("[TB] FAIL soft_redone: got edge %0d, expected %0d", done_e, base + HOLD + NS * (GAP + 1)); end
  endtask

  task automatic test_soft_vs_timeout();
    logic [NS-1:0] rdy;
    int e1, soft_e, rel0;
    rdy = '0;
    rdy[0] = 1'b1;
    do_reset(rdy);
    e1 = -1;
    for (int n = 0; n < 100 && e1 < 0; n++) begin
      tick();
      if (o_rst[1] === 1'b0) e1 = edge_no;
    end
    vectors++; if (e1 !== HOLD + GAP + 1) begin miscompares++; $display("[TB] FAIL svt_rel1: got edge %0d, expected %0d", e1, HOLD + GAP + 1); end
    while (edge_no < e1 + TMO - 1) tick();
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    soft_e = edge_no;
    vectors++; if (o_retry_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL svt_retry: got %0d, expected 0", o_retry_cnt); end
    vectors++; if (o_rst !== '1) begin miscompares++; $display("[TB] FAIL svt_rst: got %b, expected 111", o_rst); end
    rel0 = -1;
    for (int n = 0; n < 60 && rel0 < 0; n++) begin
      tick();
      if (o_rst[0] === 1'b0) rel0 = edge_no;
    end
    vectors++; if (rel0 !== soft_e + HOLD) begin miscompares++; $display("[TB] FAIL svt_rehold: got edge %0d, expected %0d", rel0, soft_e + HOLD); end
  endtask

  task automatic test_runtime_loss(input int r);
    int n0, fall_e, back_e, retry_fall;
    logic [NS-1:0] rst_fall;
    do_reset('1);
    for (int n = 0; n < 100 && o_done !== 1'b1; n++) tick();
    n0 = edge_no;
    i_ready[r] = 1'b0;
    fall_e = -1; back_e = -1; retry_fall = -1; rst_fall = '0;
    for (int n = 0; n < 150 && back_e < 0; n++) begin
      tick();
      if (edge_no == n0 + 5) i_ready[r] = 1'b1;
      if (fall_e < 0 && o_done === 1'b0) begin
        fall_e = edge_no; rst_fall = o_rst; retry_fall = int'(o_retry_cnt);
      end else if (fall_e >= 0 && o_done === 1'b1) back_e = edge_no;
    end
    vectors++; if (fall_e !== n0 + SYNC + 1) begin miscompares++; $display("[TB] FAIL loss%0d_fall: got edge %0d, expected %0d", r, fall_e, n0 + SYNC + 1); end
    vectors++; if (rst_fall !== '1) begin miscompares++; $display("[TB] FAIL loss%0d_rst: got %b, expected 111", r, rst_fall); end
    vectors++; if (retry_fall !== 0) begin miscompares++; $display("[TB] FAIL loss%0d_retry: got %0d, expected 0", r, retry_fall); end
    vectors++; if (back_e !== n0 + SYNC + 1 + HOLD + NS * (GAP + 1)) begin miscompares++; $display("[TB] FAIL loss%0d_back: got edge %0d, expected %0d", r, back_e, n0 + SYNC + 1 + HOLD + NS * (GAP + 1)); end
  endtask

  task automatic test_async_reset();
    logic [NS-1:0] rdy;
    rdy = '0;
    rdy[0] = 1'b1;
    do_reset(rdy);
    for (int n = 0; n < 100 && o_rst[1] !== 1'b0; n++) tick();
    repeat (3) tick();
    vectors++; if (o_rst !== 3'b100) begin miscompares++; $display("[TB] FAIL async_pre: got %b, expected 100", o_rst); end
    #3 i_rst_n = 1'b0;
    #1;
    vectors++; if (o_rst !== '1) begin miscompares++; $display("[TB] FAIL async_wait_rst: got %b, expected 111", o_rst); end
    vectors++; if (o_stage !== 3'd0) begin miscompares++; $display("[TB] FAIL async_wait_stage: got %0d, expected 0", o_stage); end
    do_reset('1);
    for (int n = 0; n < 100 && o_done !== 1'b1; n++) tick();
    #3 i_rst_n = 1'b0;
    #1;
    vectors++; if (o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL async_done: got %b, expected 0", o_done); end
    vectors++; if (o_rst !== '1) begin miscompares++; $display("[TB] FAIL async_done_rst: got %b, expected 111", o_rst); end
  endtask

  task automatic test_corner();
    int fall_e, done_e, fault_e, early;
    i_rst_n = 1'b0;
    c_reset(1'b1);
    fall_e = -1; done_e = -1;
    for (int n = 0; n < 60 && done_e < 0; n++) begin
      tick();
      if (fall_e < 0 && c_rst === 1'b0) fall_e = edge_no;
      if (c_done === 1'b1) done_e = edge_no;
    end
    vectors++; if (fall_e !== HOLD) begin miscompares++; $display("[TB] FAIL corner_rel: got edge %0d, expected %0d", fall_e, HOLD); end
    vectors++; if (done_e !== HOLD + 1) begin miscompares++; $display("[TB] FAIL corner_done: got edge %0d, expected %0d", done_e, HOLD + 1); end
    vectors++; if (c_stage !== 3'd1) begin miscompares++; $display("[TB] FAIL corner_stage: got %0d, expected 1", c_stage); end
    c_reset(1'b0);
    fault_e = -1; early = 0;
    for (int n = 0; n < HOLD + TMO + 40 && fault_e < 0; n++) begin
      tick();
      if (c_fault === 1'b1) fault_e = edge_no;
      else if (edge_no > HOLD && c_rst !== 1'b0) early++;
    end
    vectors++; if (fault_e !== HOLD + TMO) begin miscompares++; $display("[TB] FAIL corner_fault: got edge %0d, expected %0d", fault_e, HOLD + TMO); end
    vectors++; if (early !== 0) begin miscompares++; $display("[TB] FAIL corner_noretry: %0d reassert edges before fault, expected 0", early); end
    vectors++; if (c_rst !== 1'b1 || c_retry_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL corner_fault_out: rst %b retry %0d, expected 1 and 0", c_rst, c_retry_cnt); end
  endtask

  initial begin
    i_rst_n = 1'b0; i_soft_rst = 1'b0; i_ready = '0;
    c_rst_n = 1'b0; c_soft_rst = 1'b0; c_ready = 1'b0;
    test_reset();
    test_nominal();
    for (int it = 0; it < 3; it++) test_random_late(it);
    test_timeout_fault(0);
    test_soft_fault();
    test_timeout_fault(int'($urandom_range(1, NS - 1)));
    test_soft_fault();
    test_soft_vs_timeout();
    test_runtime_loss(int'($urandom_range(0, NS - 1)));
    test_runtime_loss(NS - 1);
    test_async_reset();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Staged reset sequencer for the capture card.
- Releases P_STAGES downstream reset domains (clocking, memory interface, link, capture datapath) one at a time, in order.
- Each stage must report ready within a timeout before the next stage is released. On timeout the whole sequence restarts, up to P_RETRY times, then latches a fault.
- Sits between the board-level reset and the per-domain reset inputs.

Parameters:
- P_STAGES, 3: number of reset domains, 1..8.
- P_HOLD_CYCLE, 16: cycles all resets stay asserted before stage 0 is released, 1..65535.
- P_GAP_CYCLE, 8: settle cycles after a stage reports ready, 0..65535. 0 means no gap.
- P_TIMEOUT, 1000: cycles allowed for a stage to report ready, 1..65535.
- P_RETRY, 2: restarts allowed after timeouts before fault, 0..15.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_soft_rst  in  1  synchronous, active-high restart request.
- i_ready  in  P_STAGES  per-stage ready/lock, asynchronous to i_clk.
- o_rst  out  P_STAGES  per-stage reset, active-high.
- o_done  out  1  all stages released and ready.
- o_fault  out  1  retries exhausted.
- o_stage  out  3  current stage index; reads P_STAGES in DONE.
- o_retry_cnt  out  4  timeouts taken in the current sequence.

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0:
  - o_rst all 1, o_done 0, o_fault 0, o_stage 0, o_retry_cnt 0.
  - State HOLD, cycle counter 0, ready synchronisers 0.
- i_ready passes through a 2-flop synchroniser per bit. All ready decisions use the synchronised value rdy_s, so there is 2 cycles of latency.
- Single 16-bit cycle counter, cleared on every state transition.
- HOLD:
  - All o_rst asserted; counter increments.
  - At the edge where counter==P_HOLD_CYCLE-1, go to WAIT with stage=0 and o_rst[0] cleared on the same edge.
- WAIT(k):
  - o_rst[0..k] are 0; all others are 1. Counter increments.
  - If rdy_s[k]=1: go to GAP(k), or directly to the next stage / DONE if P_GAP_CYCLE=0.
  - Else if counter==P_TIMEOUT-1, a timeout occurs:
    - If retry_cnt<P_RETRY: retry_cnt+1, all o_rst set to 1, go to HOLD.
    - Otherwise: go to FAULT.
  - If ready and timeout fall on the same edge, ready wins.
- GAP(k):
  - At the edge where counter==P_GAP_CYCLE-1:
    - If k<P_STAGES-1: go to WAIT(k+1) and clear o_rst[k+1].
    - Otherwise: go to DONE.
- DONE:
  - o_done=1, all o_rst 0, o_stage=P_STAGES.
  - If any rdy_s bit drops: o_done 0, all o_rst 1, go to HOLD. retry_cnt is cleared, and this restart is not counted as a retry.
- FAULT:
  - All o_rst 1, o_fault=1, o_done 0.
  - Stays in FAULT until i_soft_rst or i_rst_n.
- GAP(k) while rdy_s[k] drops: treated as a timeout, with the same retry/fault handling as in WAIT.
- i_soft_rst=1 in any state:
  - Next edge: HOLD, all o_rst 1, o_done 0, o_fault 0, retry_cnt 0, counter 0.
  - Overrides any simultaneous ready, timeout or gap-expiry event.
- Release order is strictly ascending. A released stage is never re-asserted individually; any re-assertion is global.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Nominal release (defaults, i_ready tied 1, i_rst_n released before edge 1), counting edges after release:
  - o_rst[0] falls after edge 16.
  - o_rst[1] falls after edge 25.
  - o_rst[2] falls after edge 34.
  - o_done rises after edge 43.
  - o_retry_cnt stays 0.
- Timeout to fault (i_ready[0] held 0):
  - All o_rst re-asserted after edges 1016 and 2032, with o_retry_cnt 1 then 2.
  - o_fault=1 after edge 3048; o_rst stays 3'b111 indefinitely.
- Late ready: i_ready[1] rises 300 cycles after o_rst[1] falls.
  - No retry.
  - o_rst[2] falls 2+1+8 cycles after the i_ready[1] rising edge.
- Runtime loss: in DONE, drop i_ready[2] for 5 cycles.
  - o_done falls 3 cycles later, all o_rst become 1, and the sequence restarts from HOLD with o_retry_cnt 0.
  - o_done returns once ready.
- Soft reset and async reset:
  - i_soft_rst pulse during FAULT clears o_fault on the next edge and restarts the sequence.
  - i_soft_rst on the same edge as a stage-1 timeout gives HOLD with o_retry_cnt 0.
  - i_rst_n pulled low mid-WAIT forces o_rst to all 1 and o_done to 0 immediately, without waiting for a clock edge.
- Corner parameters: P_GAP_CYCLE=0, P_RETRY=0, P_STAGES=1.
  - Ready immediate: o_done rises after edge 17.
  - Ready absent: o_fault rises after edge 1016.
